countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  Control stage that drives a two-digit (tens/ones) chain of BCD 9..0 down-counter digits.
//  Produces the digits' loadN, ena and per-digit count enables, and consumes their terminal counts.
//  Contains the prescaler that turns clk into count ticks. Detects 00 and raises timeout to game logic.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per count tick (1 s at 50 MHz); legal range >= 2
// PORTS
//  clk           in   1          system clock, rising edge
//  resetN        in   1          asynchronous active-low reset
//  start         in   1          load preset into digits and (re)start the countdown; one-cycle pulse or level
//  pause         in   1          level; freezes the countdown while high
//  tc_ones       in   1          terminal count (==0) from the ones digit
//  tc_tens       in   1          terminal count (==0) from the tens digit
//  loadN         out  1          active-low load strobe to both digits
//  ena           out  1          global enable to both digits
//  ena_cnt_ones  out  1          count enable, ones digit
//  ena_cnt_tens  out  1          count enable, tens digit
//  running       out  1          high in RUN
//  expired       out  1          high in EXPIRED (level)
//  timeout       out  1          one-cycle pulse on entry to EXPIRED
// BEHAVIOUR
//  - Interface: one clock, clk; resetN is asynchronous, active-low.
//  - Reset (any time, including mid-count): state IDLE, prescaler 0, timeout reg 0.
//    Outputs after reset: loadN=1, ena=0, both ena_cnt=0, running=0, expired=0, timeout=0.
//  - FSM states: IDLE, LOAD, RUN, PAUSE, EXPIRED.
//    IDLE:    start -> LOAD.
//    LOAD:    lasts exactly 1 cycle -> RUN (unconditional).
//    RUN:     start -> LOAD; else pause -> PAUSE; else (tick & tc_ones & tc_tens) -> EXPIRED.
//    PAUSE:   start -> LOAD; else !pause -> RUN.
//    EXPIRED: start -> LOAD.
//    start takes priority over pause and over expiry in the same cycle.
//  - Output decoding is combinational from state and tick, with no extra latency:
//    loadN=0 only in LOAD; ena=1 only in RUN; running=(state==RUN); expired=(state==EXPIRED).
//  - Start latency: start sampled at edge N gives LOAD in cycle N+1, digits loaded at edge N+2, RUN from N+2.
//  - Prescaler: counts 0..TICK_DIV-1 only in RUN. It is frozen in PAUSE, cleared in IDLE/LOAD/EXPIRED.
//    tick=1 when count==TICK_DIV-1 and state==RUN; the count wraps to 0 on that edge.
//    The first tick occurs TICK_DIV cycles after entering RUN.
//  - Count enables:
//    zero = tc_ones & tc_tens.
//    ena_cnt_ones = tick & !zero.
//    ena_cnt_tens = tick & tc_ones & !zero (tens borrows when ones wraps 0->9).
//    At 00 no enable is issued, so the digits never wrap 00->99.
//  - timeout: registered, high exactly one cycle, the cycle after the RUN->EXPIRED edge.
//  - Preset 00: LOAD->RUN, then the first tick expires with no count enable.
//  - Pause during the tick cycle: pause is evaluated first, so the tick is still issued that cycle.
//    The prescaler then holds at 0 in PAUSE.
// CONFIGURATION
//  - Macro TIMER_AUTORELOAD_EN.
//  - Defined: EXPIRED lasts 1 cycle and then goes to LOAD automatically (periodic timer).
//    timeout still pulses once per expiry; expired is high for that 1 cycle.
//  - Undefined: EXPIRED holds until start or reset.
// STRUCTURE
//  - Package timer_pkg: typedef enum logic [2:0] timer_state_t {IDLE, LOAD, RUN, PAUSE, EXPIRED};
//    localparam int TICK_DIV_DEFAULT = 50_000_000.
//  - Sub-module tick_generator: params TICK_DIV; ports clk, resetN, run, clear -> tick.
//    Prescaler width is $clog2(TICK_DIV).
//  - Top: FSM, enable decode, timeout register.
// TESTING  (TICK_DIV=4; bench models two 9..0 digits with preset 12)
//  - Reset mid-RUN: assert resetN=0 -> same cycle loadN=1, ena=0, running=0; after release, IDLE holds without start.
//  - start pulse at cycle 0 -> loadN=0 in cycle 1 only; running=1 from cycle 2;
//    first ena_cnt_ones in cycle 5; digits read 11.
//  - Preset 10, run -> at count 10 the tick gives ena_cnt_ones=1 and ena_cnt_tens=1, and digits read 09.
//  - Count down to 00 -> next tick: no ena_cnt, state EXPIRED, timeout=1 for exactly 1 cycle, digits stay 00.
//  - pause high for 20 cycles mid-count -> no ena_cnt, digits frozen; after release the next tick comes
//    TICK_DIV minus the cycles already elapsed before pause.
//  - start and pause together in RUN -> LOAD wins.
//  - TIMER_AUTORELOAD_EN defined -> after timeout, LOAD is automatic and the digits reload to 12.
//  - Preset 00 -> first tick gives EXPIRED, digits never show 99.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the two-digit BCD countdown timer control stage.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        EXPIRED
    } timer_state_t;

    localparam int TICK_DIV_DEFAULT = 50_000_000;

    // The prescaler only advances while the countdown is actually running.
    function automatic logic prescaleRuns(input timer_state_t state);
        return (state == RUN);
    endfunction

    // Idle, load and expired restart the prescaler from zero; pause keeps its phase.
    function automatic logic prescaleClears(input timer_state_t state);
        return (state == IDLE) || (state == LOAD) || (state == EXPIRED);
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_generator.sv
// Prescaler turning clk into one-cycle count ticks every TICK_DIV cycles of run.
module tick_generator
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int              W    = $clog2(TICK_DIV);
    localparam logic [W-1:0]    LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         atLast;

    assign atLast = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            if (atLast) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && atLast;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer control: FSM, digit enable decode and timeout pulse register.
// Build option TIMER_AUTORELOAD_EN makes EXPIRED reload automatically after one cycle.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic start,
    input  logic pause,
    input  logic tc_ones,
    input  logic tc_tens,
    output logic loadN,
    output logic ena,
    output logic ena_cnt_ones,
    output logic ena_cnt_tens,
    output logic running,
    output logic expired,
    output logic timeout
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic         timeout_q;
    logic         timeout_d;
    logic         tick;
    logic         zero;

    assign zero = tc_ones && tc_tens;

    tick_generator #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_generator (
        .clk    (clk),
        .resetN (resetN),
        .run    (prescaleRuns(state_q)),
        .clear  (prescaleClears(state_q)),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    // start outranks pause, and pause outranks expiry, in every state that honours them.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (start) begin
                    state_d = LOAD;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (tick && zero) begin
                    state_d = EXPIRED;
                end
            end
            PAUSE: begin
                if (start) begin
                    state_d = LOAD;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            EXPIRED: begin
`ifdef TIMER_AUTORELOAD_EN
                state_d = LOAD;
`else
                if (start) state_d = LOAD;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timeout_d = (state_q == RUN) && (state_d == EXPIRED);

    // Enables are withheld at 00 so the digit chain can never wrap to 99.
    always_comb begin
        loadN        = 1'b1;
        ena          = 1'b0;
        ena_cnt_ones = 1'b0;
        ena_cnt_tens = 1'b0;
        running      = 1'b0;
        expired      = 1'b0;
        unique case (state_q)
            LOAD: begin
                loadN = 1'b0;
            end
            RUN: begin
                ena          = 1'b1;
                running      = 1'b1;
                ena_cnt_ones = tick && !zero;
                ena_cnt_tens = tick && tc_ones && !zero;
            end
            EXPIRED: begin
                expired = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICK_DIV=4 and a modelled pair of BCD digits.
module tb_countdown_timer_ctrl;

    logic clk;
    logic resetN;
    logic start;
    logic pause;
    logic tcOnes;
    logic tcTens;
    logic loadN;
    logic ena;
    logic ena_cnt_ones;
    logic ena_cnt_tens;
    logic running;
    logic expired;
    logic timeout;

    logic [3:0] presetTens;
    logic [3:0] presetOnes;
    logic [3:0] onesQ = 4'd0;
    logic [3:0] tensQ = 4'd0;
    logic [7:0] digits;

    int compCount;
    int errCount;
    int waitCount;
    logic sawEnable;

    countdown_timer_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .pause        (pause),
        .tc_ones      (tcOnes),
        .tc_tens      (tcTens),
        .loadN        (loadN),
        .ena          (ena),
        .ena_cnt_ones (ena_cnt_ones),
        .ena_cnt_tens (ena_cnt_tens),
        .running      (running),
        .expired      (expired),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two 9..0 down-counting digits driven by the controller's strobes.
    always @(posedge clk) begin
        if (!loadN) begin
            onesQ <= presetOnes;
            tensQ <= presetTens;
        end else if (ena) begin
            if (ena_cnt_ones) onesQ <= (onesQ == 4'd0) ? 4'd9 : onesQ - 4'd1;
            if (ena_cnt_tens) tensQ <= (tensQ == 4'd0) ? 4'd9 : tensQ - 4'd1;
        end
    end

    assign tcOnes = (onesQ == 4'd0);
    assign tcTens = (tensQ == 4'd0);
    assign digits = {tensQ, onesQ};

    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        pause = p;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compCount  = 0;
        errCount   = 0;
        resetN     = 1'b0;
        presetTens = 4'd1;
        presetOnes = 4'd2;
        applyStimulus(1'b0, 1'b0);

        @(negedge clk);
        checkOutput("rst_loadN", {7'd0, loadN}, 8'd1);
        checkOutput("rst_ena", {7'd0, ena}, 8'd0);
        checkOutput("rst_cnt", {6'd0, ena_cnt_tens, ena_cnt_ones}, 8'd0);
        checkOutput("rst_running", {7'd0, running}, 8'd0);
        checkOutput("rst_expired", {7'd0, expired}, 8'd0);
        checkOutput("rst_timeout", {7'd0, timeout}, 8'd0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_running", {7'd0, running}, 8'd0);
        checkOutput("idle_loadN", {7'd0, loadN}, 8'd1);

        $display("[TB] start with preset 12");
        applyStimulus(1'b1, 1'b0);
        checkOutput("c0_loadN", {7'd0, loadN}, 8'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c1_loadN", {7'd0, loadN}, 8'd0);
        checkOutput("c1_running", {7'd0, running}, 8'd0);
        @(negedge clk);
        checkOutput("c2_loadN", {7'd0, loadN}, 8'd1);
        checkOutput("c2_running", {7'd0, running}, 8'd1);
        checkOutput("c2_digits", digits, 8'h12);
        @(negedge clk);
        checkOutput("c3_cntOnes", {7'd0, ena_cnt_ones}, 8'd0);
        @(negedge clk);
        checkOutput("c4_cntOnes", {7'd0, ena_cnt_ones}, 8'd0);
        @(negedge clk);
        checkOutput("c5_cntOnes", {7'd0, ena_cnt_ones}, 8'd1);
        checkOutput("c5_cntTens", {7'd0, ena_cnt_tens}, 8'd0);
        @(negedge clk);
        checkOutput("c6_digits", digits, 8'h11);

        repeat (7) @(negedge clk);
        checkOutput("c13_digits", digits, 8'h10);
        checkOutput("c13_cntOnes", {7'd0, ena_cnt_ones}, 8'd1);
        checkOutput("c13_cntTens", {7'd0, ena_cnt_tens}, 8'd1);
        @(negedge clk);
        checkOutput("c14_digits", digits, 8'h09);

        $display("[TB] pause for 20 cycles after 2 prescaler cycles");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        sawEnable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ena || ena_cnt_ones || ena_cnt_tens) sawEnable = 1'b1;
        end
        checkOutput("pause_noEnable", {7'd0, sawEnable}, 8'd0);
        checkOutput("pause_digits", digits, 8'h09);
        checkOutput("pause_running", {7'd0, running}, 8'd0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("resume_running", {7'd0, running}, 8'd1);
        checkOutput("resume_cnt0", {7'd0, ena_cnt_ones}, 8'd0);
        @(negedge clk);
        checkOutput("resume_tick", {7'd0, ena_cnt_ones}, 8'd1);
        @(negedge clk);
        checkOutput("resume_digits", digits, 8'h08);

        waitCount = 0;
        while (digits != 8'h00 && waitCount < 100) begin
            @(negedge clk);
            waitCount++;
        end
        checkOutput("reach00", digits, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("zero_cnt", {6'd0, ena_cnt_tens, ena_cnt_ones}, 8'd0);
        checkOutput("zero_running", {7'd0, running}, 8'd1);
        checkOutput("zero_timeout", {7'd0, timeout}, 8'd0);
        @(negedge clk);
        checkOutput("exp_expired", {7'd0, expired}, 8'd1);
        checkOutput("exp_timeout", {7'd0, timeout}, 8'd1);
        checkOutput("exp_running", {7'd0, running}, 8'd0);
        checkOutput("exp_digits", digits, 8'h00);
        @(negedge clk);
        checkOutput("exp_timeoutOnce", {7'd0, timeout}, 8'd0);
`ifdef TIMER_AUTORELOAD_EN
        checkOutput("reload_loadN", {7'd0, loadN}, 8'd0);
        checkOutput("reload_expired", {7'd0, expired}, 8'd0);
        @(negedge clk);
        checkOutput("reload_running", {7'd0, running}, 8'd1);
        checkOutput("reload_digits", digits, 8'h12);
`else
        checkOutput("hold_expired", {7'd0, expired}, 8'd1);
        repeat (3) @(negedge clk);
        checkOutput("hold_expiredLate", {7'd0, expired}, 8'd1);
        checkOutput("hold_digits", digits, 8'h00);
        checkOutput("hold_timeout", {7'd0, timeout}, 8'd0);
`endif

        $display("[TB] start and pause together in RUN");
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_loadN", {7'd0, loadN}, 8'd0);
        @(negedge clk);
        checkOutput("restart_running", {7'd0, running}, 8'd1);
        checkOutput("restart_digits", digits, 8'h12);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("both_loadN", {7'd0, loadN}, 8'd0);
        checkOutput("both_running", {7'd0, running}, 8'd0);
        @(negedge clk);
        checkOutput("both_loadToRun", {7'd0, running}, 8'd1);
        @(negedge clk);
        checkOutput("both_paused", {7'd0, running}, 8'd0);

        $display("[TB] preset 00");
        presetTens = 4'd0;
        presetOnes = 4'd0;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("p00_loadN", {7'd0, loadN}, 8'd0);
        @(negedge clk);
        checkOutput("p00_running", {7'd0, running}, 8'd1);
        checkOutput("p00_digits", digits, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("p00_noCnt", {6'd0, ena_cnt_tens, ena_cnt_ones}, 8'd0);
        @(negedge clk);
        checkOutput("p00_expired", {7'd0, expired}, 8'd1);
        checkOutput("p00_timeout", {7'd0, timeout}, 8'd1);
        @(negedge clk);
        checkOutput("p00_noWrap", digits, 8'h00);

        $display("[TB] reset mid-RUN");
        presetTens = 4'd1;
        presetOnes = 4'd2;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_running", {7'd0, running}, 8'd1);
        resetN = 1'b0;
        #1;
        checkOutput("midRst_loadN", {7'd0, loadN}, 8'd1);
        checkOutput("midRst_ena", {7'd0, ena}, 8'd0);
        checkOutput("midRst_running", {7'd0, running}, 8'd0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_running", {7'd0, running}, 8'd0);
        checkOutput("post_loadN", {7'd0, loadN}, 8'd1);
        checkOutput("post_expired", {7'd0, expired}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
